mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative 32-bit multiply/divide unit in the execute stage, beside the ALU; takes the same srca/srcb operands.
//  Implements MULT, MULTU, DIV and DIVU into HI/LO, plus MTHI/MTLO writes. HI/LO feed the MFHI/MFLO result mux.
//  Uses a start/busy/done handshake; the controller stalls while busy is high.
// PARAMETERS
//  WIDTH    32   operand width; HI and LO are each WIDTH bits
//  CNT_W     6   width of the iteration counter (must cover WIDTH)
// PORTS
//  clk        in   1      single clock; all state changes on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      request an operation; sampled only when busy=0
//  op         in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  srca       in   WIDTH  multiplicand / dividend
//  srcb       in   WIDTH  multiplier / divisor
//  hi_we      in   1      MTHI: hi <= wdata
//  lo_we      in   1      MTLO: lo <= wdata
//  wdata      in   WIDTH  MTHI/MTLO data
//  busy       out  1      operation in flight
//  done       out  1      one-cycle pulse: hi/lo hold a new result
//  hi         out  WIDTH  HI register (product high half / remainder)
//  lo         out  WIDTH  LO register (product low half / quotient)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; busy=0, done=0, hi=0, lo=0; counter and working registers cleared.
//    Reset in mid-operation abandons the operation; no done pulse follows.
//  - FSM IDLE -> CALC -> FIX -> IDLE.
//    IDLE: start=1 at edge k latches op, abs(srca), abs(srcb) and the result signs (signed ops only),
//    clears the accumulator and counter, and moves to CALC.
//  - CALC: one iteration per edge for WIDTH edges (k+1..k+WIDTH), then moves to FIX.
//    Multiply iteration: shift-add on a 2*WIDTH accumulator.
//    Divide iteration: restoring shift-subtract, one quotient bit per edge.
//  - FIX (edge k+WIDTH+1): applies sign correction and writes hi/lo, then returns to IDLE; done=1 for that cycle only.
//  - busy=1 in the cycles after edges k..k+WIDTH (33 cycles for WIDTH=32); busy=0 while done=1.
//    Total latency from the start edge to the hi/lo update is WIDTH+1 edges.
//  - start while busy=1 is ignored (not queued). start in the done cycle is accepted.
//  - Signed multiply: product negated (two's complement, 2*WIDTH bits) when the operand signs differ.
//  - Signed divide: quotient negative when the operand signs differ; remainder takes the sign of the dividend.
//  - Divide by zero: lo=all ones, hi=original srca, for both DIV and DIVU; no sign fix.
//  - DIV 0x80000000 / -1: lo=0x80000000, hi=0 (natural wrap). No exceptions are raised.
//  - hi_we/lo_we apply at the edge only when busy=0; they are ignored while busy.
//    If asserted with an accepted start, the write applies but is overwritten by the result.
//    If asserted in the done cycle, the write wins at the next edge.
// STRUCTURE
//  - Shared package mdu_pkg: op encodings (MDU_MULT/MULTU/DIV/DIVU), FSM state encodings (IDLE/CALC/FIX), WIDTH.
//  - One sub-module, mdu_step: combinational single iteration (shift-add or shift-subtract) on
//    {acc_hi, acc_lo} and divisor. The top level holds the FSM, counter, sign fix and the HI/LO registers.
// TESTING
//  - MULTU 0xFFFFFFFF*0xFFFFFFFF -> done 33 cycles after busy rises; hi=0xFFFFFFFE, lo=0x00000001.
//  - MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT -4*-5 -> hi=0, lo=20.
//  - DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100/7 -> lo=14, hi=2.
//  - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  - start pulsed mid-CALC with new operands -> ignored, first result intact.
//    start in the done cycle -> accepted, back-to-back results correct.
//  - rst_n low at CALC cycle 10 -> busy=0, hi=lo=0 immediately, no done.
//    hi_we while busy ignored; hi_we when idle -> hi=wdata next edge.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encodings and the default operand width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of the multiply/divide datapath: shift-add for
// multiply, restoring shift-subtract for divide, on the {acc_hi, acc_lo} pair.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    rem_sh = {acc_hi, acc_lo[WIDTH-1]};
    diff   = rem_sh - {1'b0, operand};
    if (is_div) begin
      // A clear top bit of diff means the trial subtraction did not borrow.
      if (!diff[WIDTH]) begin
        nxt_hi = diff[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = rem_sh[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers, start/busy/done handshake
// and MTHI/MTLO writes. One datapath iteration per clock, sign fix-up at the end.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  mdu_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  mdu_op_e          op_r;
  logic [WIDTH-1:0] acc_hi, acc_lo, operand_r, orig_a;
  logic             neg_q, neg_r, div_zero;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             done_r;

  logic             is_div;
  logic             signed_op;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [2*WIDTH-1:0] prod;

  assign is_div    = (op_r == MDU_DIV) || (op_r == MDU_DIVU);
  assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (operand_r),
    .nxt_hi  (step_hi),
    .nxt_lo  (step_lo)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sign correction of the magnitude result, plus the divide-by-zero override.
  always_comb begin
    prod   = {acc_hi, acc_lo};
    res_hi = acc_hi;
    res_lo = acc_lo;
    if (!is_div) begin
      if (neg_q) prod = -prod;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (div_zero) begin
      res_hi = orig_a;
      res_lo = '1;
    end else begin
      res_hi = cond_neg(acc_hi, neg_r);
      res_lo = cond_neg(acc_lo, neg_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_r      <= MDU_MULT;
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand_r <= '0;
      orig_a    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
      done_r    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= (state == FIX);
      case (state)
        IDLE: begin
          if (hi_we) hi_r <= wdata;
          if (lo_we) lo_r <= wdata;
          if (start) begin
            op_r      <= mdu_op_e'(op);
            acc_hi    <= '0;
            acc_lo    <= abs_val(srca, signed_op);
            operand_r <= abs_val(srcb, signed_op);
            orig_a    <= srca;
            neg_q     <= signed_op && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            neg_r     <= signed_op && srca[WIDTH-1];
            div_zero  <= (srcb == '0);
            cnt       <= '0;
          end
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CNT_W'(1);
        end
        FIX: begin
          hi_r <= res_hi;
          lo_r <= res_lo;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic results, latency, handshake,
// MTHI/MTLO behaviour and asynchronous reset mid-operation.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srca = '0, srcb = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  mul_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    srca  = a;
    srcb  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 40);
    check({tag, "_done_seen"}, {31'b0, done}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    start_op(o, a, b);
    wait_done(tag, n);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int n;
    int seen;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst_n = 1'b1;
    tick();

    // MULTU with latency and handshake timing
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy_rise", {31'b0, busy}, 32'd1);
    wait_done("multu_ff", n);
    check("multu_latency", 32'(n), 32'd33);
    check("multu_busy_at_done", {31'b0, busy}, 32'd0);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    tick();
    check("done_pulse_one_cycle", {31'b0, done}, 32'd0);

    run_op("mult_m3x7",  2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_m4xm5", 2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'd0, 32'd20);
    run_op("div_m7d2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7dm2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_5d0",   2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div_m5d0",   2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("div_minm1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // start while busy must be ignored
    start_op(2'b01, 32'd6, 32'd7);
    repeat (5) tick();
    op = 2'b11; srca = 32'd1000; srcb = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ignore_start", n);
    check("ignore_start_latency", 32'(n), 32'd27);
    check("ignore_start_hi", hi, 32'd0);
    check("ignore_start_lo", lo, 32'd42);

    // start in the done cycle is accepted
    start_op(2'b11, 32'd100, 32'd7);
    wait_done("b2b_first", n);
    check("b2b_first_lo", lo, 32'd14);
    start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done("b2b_second", n);
    check("b2b_second_latency", 32'(n), 32'd33);
    check("b2b_second_hi", hi, 32'hFFFF_FFFF);
    check("b2b_second_lo", lo, 32'hFFFF_FFEB);

    // MTHI while busy ignored; MTLO in the done cycle wins
    start_op(2'b01, 32'd2, 32'd3);
    repeat (3) tick();
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    hi_we = 1'b0;
    check("hi_we_busy_ignored", hi, 32'hFFFF_FFFF);
    wait_done("mtx_op", n);
    check("mtx_op_hi", hi, 32'd0);
    check("mtx_op_lo", lo, 32'd6);
    lo_we = 1'b1; wdata = 32'h1234_5678;
    tick();
    lo_we = 1'b0;
    check("lo_we_done_cycle", lo, 32'h1234_5678);
    hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    tick();
    hi_we = 1'b0;
    check("hi_we_idle", hi, 32'hCAFE_F00D);
    check("hi_we_idle_lo_kept", lo, 32'h1234_5678);

    // asynchronous reset mid-CALC abandons the operation
    start_op(2'b11, 32'd100, 32'd7);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    check("midrst_lo_after", lo, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
